// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: 32-bit word, arbiter state encoding
// and the default starvation bound for the instruction port.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_t;

  // Consecutive data-port grants tolerated while the instruction port waits.
  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port to single physical-memory arbiter. Port B (data) normally wins
// ties; port A (instruction) is forced after STARVE_LIMIT consecutive B grants.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | no pmem transaction; arbitrate and latch the winner
//   SERVE_A | port-A read outstanding on pmem, wait for pmem_resp
//   SERVE_B | port-B read or write outstanding on pmem, wait for pmem_resp
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  // port A (instruction)
  input  logic       read_a,
  input  rv32i_word  address_a,
  output logic       resp_a,
  output rv32i_word  rdata_a,
  // port B (data)
  input  logic       read_b,
  input  logic       write,
  input  logic [3:0] wmask,
  input  rv32i_word  address_b,
  input  rv32i_word  wdata,
  output logic       resp_b,
  output rv32i_word  rdata_b,
  // physical memory
  output logic       pmem_read,
  output logic       pmem_write,
  output rv32i_word  pmem_address,
  output rv32i_word  pmem_wdata,
  output logic [3:0] pmem_wmask,
  input  logic       pmem_resp,
  input  rv32i_word  pmem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [CNT_W-1:0] r_starve_cnt;
  rv32i_word        r_addr;
  rv32i_word        r_wdata;
  logic [3:0]       r_wmask;
  logic             r_is_write;
  logic             w_req_b;
  logic             w_grant_a;
  logic             w_grant_b;

  assign w_req_b = read_b | write;

  // State register; reset drops any in-flight transaction immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Arbitration and next-state: grants only happen from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_a && w_req_b) begin
          if (r_starve_cnt == LIMIT_C) w_grant_a = 1'b1;
          else                         w_grant_b = 1'b1;
        end else if (read_a) begin
          w_grant_a = 1'b1;
        end else if (w_req_b) begin
          w_grant_b = 1'b1;
        end
        if (w_grant_a)      w_next_state = SERVE_A;
        else if (w_grant_b) w_next_state = SERVE_B;
      end
      SERVE_A, SERVE_B: begin
        if (pmem_resp) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Starvation counter: counts B wins over a waiting A, saturating at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant_a || !read_a)
        r_starve_cnt <= '0;
      else if (w_grant_b && (r_starve_cnt != LIMIT_C))
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Request latch: pmem sees only the values captured at grant time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_is_write <= 1'b0;
    end else if (w_grant_a) begin
      r_addr     <= address_a;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_is_write <= 1'b0;
    end else if (w_grant_b) begin
      r_addr     <= address_b;
      r_wdata    <= wdata;
      r_wmask    <= wmask;
      r_is_write <= write;   // write wins when read_b is also high
    end
  end

  assign pmem_read    = (r_state == SERVE_A) || ((r_state == SERVE_B) && !r_is_write);
  assign pmem_write   = (r_state == SERVE_B) && r_is_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign pmem_wmask   = r_wmask;

  assign resp_a  = pmem_resp && (r_state == SERVE_A);
  assign resp_b  = pmem_resp && (r_state == SERVE_B);
  assign rdata_a = pmem_rdata;
  assign rdata_b = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change and outputs are sampled
// on the falling clock edge, away from the rising active edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .read_a       (read_a),
    .address_a    (address_a),
    .resp_a       (resp_a),
    .rdata_a      (rdata_a),
    .read_b       (read_b),
    .write        (write),
    .wmask        (wmask),
    .address_b    (address_b),
    .wdata        (wdata),
    .resp_b       (resp_b),
    .rdata_b      (rdata_b),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read_a = 0; read_b = 0; write = 0; wmask = 0;
    address_a = 0; address_b = 0; wdata = 0; pmem_resp = 0; pmem_rdata = 0;
    step(); step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL reset_strobes got=%b exp=00", {pmem_read, pmem_write}); else n_pass++;
    n_total++; if ({resp_a, resp_b} !== 2'b00) $display("FAIL reset_resp got=%b exp=00", {resp_a, resp_b}); else n_pass++;
    n_total++; if (pmem_address !== 32'h0) $display("FAIL reset_addr got=%h exp=0", pmem_address); else n_pass++;
    reset_n = 1'b1;
    step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL idle_no_req got=%b exp=00", {pmem_read, pmem_write}); else n_pass++;
  endtask

  task automatic test_a_only();
    read_a = 1'b1; address_a = 32'h0000_0100;
    step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b10) $display("FAIL a_only_strobe got=%b exp=10", {pmem_read, pmem_write}); else n_pass++;
    n_total++; if (pmem_address !== 32'h100) $display("FAIL a_only_addr got=%h exp=100", pmem_address); else n_pass++;
    n_total++; if (resp_a !== 1'b0) $display("FAIL a_only_early_resp got=%b exp=0", resp_a); else n_pass++;
    step(); step();
    pmem_resp = 1'b1; pmem_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if ({resp_a, resp_b} !== 2'b10) $display("FAIL a_only_resp got=%b exp=10", {resp_a, resp_b}); else n_pass++;
    n_total++; if (rdata_a !== 32'hDEAD_BEEF) $display("FAIL a_only_rdata got=%h exp=deadbeef", rdata_a); else n_pass++;
    step();
    pmem_resp = 1'b0; read_a = 1'b0;
    #1;
    n_total++; if ({pmem_read, resp_a} !== 2'b00) $display("FAIL a_only_done got=%b exp=00", {pmem_read, resp_a}); else n_pass++;
    step();
  endtask

  task automatic test_simultaneous_and_latch();
    read_a = 1'b1; address_a = 32'h0000_0140;
    write = 1'b1; address_b = 32'h0000_0200; wdata = 32'h1234_5678; wmask = 4'b0011;
    step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b01) $display("FAIL simul_b_first got=%b exp=01", {pmem_read, pmem_write}); else n_pass++;
    n_total++; if (pmem_wmask !== 4'b0011) $display("FAIL simul_wmask got=%b exp=0011", pmem_wmask); else n_pass++;
    n_total++; if (pmem_wdata !== 32'h1234_5678) $display("FAIL simul_wdata got=%h exp=12345678", pmem_wdata); else n_pass++;
    address_b = 32'h0000_0300; wdata = 32'hFFFF_FFFF; wmask = 4'b1111;
    step();
    n_total++; if (pmem_address !== 32'h200) $display("FAIL latch_addr got=%h exp=200", pmem_address); else n_pass++;
    n_total++; if (pmem_wmask !== 4'b0011) $display("FAIL latch_wmask got=%b exp=0011", pmem_wmask); else n_pass++;
    pmem_resp = 1'b1; pmem_rdata = 32'h0;
    #1;
    n_total++; if ({resp_a, resp_b} !== 2'b01) $display("FAIL simul_resp_b got=%b exp=01", {resp_a, resp_b}); else n_pass++;
    n_total++; if (pmem_address !== 32'h200) $display("FAIL latch_addr_at_resp got=%h exp=200", pmem_address); else n_pass++;
    step();
    pmem_resp = 1'b0; write = 1'b0;
    n_total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL simul_idle_gap got=%b exp=00", {pmem_read, pmem_write}); else n_pass++;
    step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b10) $display("FAIL simul_a_next got=%b exp=10", {pmem_read, pmem_write}); else n_pass++;
    n_total++; if (pmem_address !== 32'h140) $display("FAIL simul_a_addr got=%h exp=140", pmem_address); else n_pass++;
    pmem_resp = 1'b1; pmem_rdata = 32'hCAFE_F00D;
    #1;
    n_total++; if ({resp_a, resp_b} !== 2'b10) $display("FAIL simul_resp_a got=%b exp=10", {resp_a, resp_b}); else n_pass++;
    n_total++; if (rdata_a !== 32'hCAFE_F00D) $display("FAIL simul_rdata_a got=%h exp=cafef00d", rdata_a); else n_pass++;
    step();
    pmem_resp = 1'b0; read_a = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_a;
    logic [31:0] exp_addr;
    exp_a = 10'b1000010000;  // bit i: transaction i goes to A (B,B,B,B,A,B,B,B,B,A)
    read_a = 1'b1; address_a = 32'h0000_0400;
    read_b = 1'b1; address_b = 32'h0000_0500;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_addr = exp_a[i] ? 32'h400 : 32'h500;
      n_total++; if (pmem_address !== exp_addr || pmem_read !== 1'b1)
        $display("FAIL starve_grant_%0d got=%h/%b exp=%h/1", i, pmem_address, pmem_read, exp_addr); else n_pass++;
      pmem_resp = 1'b1;
      #1;
      n_total++; if ({resp_a, resp_b} !== {exp_a[i], ~exp_a[i]})
        $display("FAIL starve_resp_%0d got=%b exp=%b", i, {resp_a, resp_b}, {exp_a[i], ~exp_a[i]}); else n_pass++;
      step();
      pmem_resp = 1'b0;
    end
    read_a = 1'b0; read_b = 1'b0;
    step();
  endtask

  task automatic test_write_wins_and_drop();
    read_b = 1'b1; write = 1'b1; address_b = 32'h0000_0700; wdata = 32'hA5A5_5A5A; wmask = 4'b1100;
    step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b01) $display("FAIL rw_is_write got=%b exp=01", {pmem_read, pmem_write}); else n_pass++;
    read_b = 1'b0; write = 1'b0;
    step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b01) $display("FAIL drop_still_running got=%b exp=01", {pmem_read, pmem_write}); else n_pass++;
    pmem_resp = 1'b1;
    #1;
    n_total++; if ({resp_a, resp_b} !== 2'b01) $display("FAIL drop_resp_b got=%b exp=01", {resp_a, resp_b}); else n_pass++;
    step();
    pmem_resp = 1'b0;
    step();
    n_total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL drop_back_idle got=%b exp=00", {pmem_read, pmem_write}); else n_pass++;
  endtask

  task automatic test_idle_resp();
    pmem_resp = 1'b1;
    #1;
    n_total++; if ({resp_a, resp_b} !== 2'b00) $display("FAIL idle_resp got=%b exp=00", {resp_a, resp_b}); else n_pass++;
    step();
    pmem_resp = 1'b0;
    n_total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL idle_resp_stay got=%b exp=00", {pmem_read, pmem_write}); else n_pass++;
  endtask

  task automatic test_async_reset();
    read_a = 1'b1; address_a = 32'h0000_0600;
    step();
    n_total++; if (pmem_read !== 1'b1) $display("FAIL areset_pre got=%b exp=1", pmem_read); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (pmem_read !== 1'b0) $display("FAIL areset_drop got=%b exp=0", pmem_read); else n_pass++;
    n_total++; if (pmem_address !== 32'h0) $display("FAIL areset_latch got=%h exp=0", pmem_address); else n_pass++;
    read_a = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    pmem_resp = 1'b1;
    #1;
    n_total++; if ({resp_a, resp_b} !== 2'b00) $display("FAIL areset_late_resp got=%b exp=00", {resp_a, resp_b}); else n_pass++;
    step();
    pmem_resp = 1'b0;
    n_total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL areset_idle got=%b exp=00", {pmem_read, pmem_write}); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_a_only();
    test_simultaneous_and_latch();
    test_starvation();
    test_write_wins_and_drop();
    test_idle_resp();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
